alu_seq: RTL

Parametrised, multi-cycle successor to the pipeline's single-cycle ALU. It generalises the datapath to `WIDTH` bits and adds an iterative unsigned/signed multiplier and an optional restoring divider. Operands enter through a valid/ready handshake; results leave through a registered, one-cycle `out_valid` pulse. It sits in the EX stage, and the hazard unit stalls issue while `in_ready` is low.

---
 rtl/alu_seq.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with saturating add/sub, bitwise ops, shifts and an iterative multiplier.
// Define ALU_DIV_EN to compile in the restoring divider (DIVU/REMU).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] dst,
  output logic             ov,
  output logic             zr,
  output logic             neg
);

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_NOR  = 4'd3;
  localparam logic [3:0] F_SLL  = 4'd4;
  localparam logic [3:0] F_SRL  = 4'd5;
  localparam logic [3:0] F_SRA  = 4'd6;
  localparam logic [3:0] F_OR   = 4'd7;
  localparam logic [3:0] F_XOR  = 4'd8;
  localparam logic [3:0] F_MULU = 4'd9;
  localparam logic [3:0] F_MULS = 4'd10;
`ifdef ALU_DIV_EN
  localparam logic [3:0] F_DIVU = 4'd11;
  localparam logic [3:0] F_REMU = 4'd12;
`endif

  localparam logic [WIDTH-1:0]   MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] LIM_NEG = {{WIDTH{1'b0}}, MIN_NEG};
  localparam logic [2*WIDTH-1:0] LIM_POS = {{WIDTH{1'b0}}, MAX_POS};
  localparam logic [SHW-1:0]     LAST    = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ALU_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t state, state_next;

  logic [SHW-1:0]     cnt;
  logic               last_iter;
  logic               is_mul;
  logic               long_op;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;
  logic [2*WIDTH-1:0] mcand, prod, prod_next;
  logic [WIDTH-1:0]   mplier;
  logic               mul_signed, mul_neg;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_ov;
  logic               res_fire;
  logic [WIDTH-1:0]   res_val;
  logic               res_ov;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   dquot, ddiv, drem;
  logic               rem_sel;
  logic [WIDTH:0]     dshift, dsub;
  logic [WIDTH-1:0]   rem_next, quot_next, div_res;
  logic               div_zero, div_ov;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign last_iter = (cnt == LAST);
  assign is_mul    = (func == F_MULU) || (func == F_MULS);
`ifdef ALU_DIV_EN
  assign long_op   = is_mul || (func == F_DIVU) || (func == F_REMU);
`else
  assign long_op   = is_mul;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid && is_mul) state_next = S_MUL;
`ifdef ALU_DIV_EN
        else if (in_valid && long_op) state_next = S_DIV;
`endif
      end
      S_MUL: if (last_iter) state_next = S_IDLE;
`ifdef ALU_DIV_EN
      S_DIV: if (div_zero || last_iter) state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Single-cycle ops; the extra top bit of sum/diff detects signed overflow.
  always_comb begin
    sum     = {src1[WIDTH-1], src1} + {src0[WIDTH-1], src0};
    diff    = {src1[WIDTH-1], src1} - {src0[WIDTH-1], src0};
    alu_res = '0;
    alu_ov  = 1'b0;
    case (func)
      F_ADD: begin
        if (sum[WIDTH] != sum[WIDTH-1]) begin
          alu_res = sum[WIDTH] ? MIN_NEG : MAX_POS;
          alu_ov  = 1'b1;
        end else begin
          alu_res = sum[WIDTH-1:0];
        end
      end
      F_SUB: begin
        if (diff[WIDTH] != diff[WIDTH-1]) begin
          alu_res = diff[WIDTH] ? MIN_NEG : MAX_POS;
          alu_ov  = 1'b1;
        end else begin
          alu_res = diff[WIDTH-1:0];
        end
      end
      F_AND:   alu_res = src1 & src0;
      F_NOR:   alu_res = ~(src1 | src0);
      F_OR:    alu_res = src1 | src0;
      F_XOR:   alu_res = src1 ^ src0;
      F_SLL:   alu_res = src1 << shamt;
      F_SRL:   alu_res = src1 >> shamt;
      F_SRA:   alu_res = $signed(src1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // prod_next already includes the current multiplier bit, so the last iteration can finish directly.
  always_comb begin
    prod_next = prod + (mplier[0] ? mcand : '0);
    mul_res   = prod_next[WIDTH-1:0];
    mul_ov    = 1'b0;
    if (!mul_signed) begin
      if (prod_next[2*WIDTH-1:WIDTH] != '0) begin
        mul_res = '1;
        mul_ov  = 1'b1;
      end
    end else if (mul_neg) begin
      if (prod_next > LIM_NEG) begin
        mul_res = MIN_NEG;
        mul_ov  = 1'b1;
      end else begin
        mul_res = -prod_next[WIDTH-1:0];
      end
    end else if (prod_next > LIM_POS) begin
      mul_res = MAX_POS;
      mul_ov  = 1'b1;
    end
  end

`ifdef ALU_DIV_EN
  always_comb begin
    dshift    = {drem, dquot[WIDTH-1]};
    dsub      = dshift - {1'b0, ddiv};
    rem_next  = dsub[WIDTH] ? dshift[WIDTH-1:0] : dsub[WIDTH-1:0];
    quot_next = {dquot[WIDTH-2:0], ~dsub[WIDTH]};
    div_zero  = (ddiv == '0);
    if (div_zero) begin
      div_res = rem_sel ? dquot : '1;
      div_ov  = 1'b1;
    end else begin
      div_res = rem_sel ? rem_next : quot_next;
      div_ov  = 1'b0;
    end
  end
`endif

  always_comb begin
    in_ready = (state == S_IDLE);
    res_fire = 1'b0;
    res_val  = alu_res;
    res_ov   = alu_ov;
    case (state)
      S_IDLE: res_fire = in_valid && !long_op;
      S_MUL: begin
        res_fire = last_iter;
        res_val  = mul_res;
        res_ov   = mul_ov;
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        res_fire = div_zero || last_iter;
        res_val  = div_res;
        res_ov   = div_ov;
      end
`endif
      default: res_fire = 1'b0;
    endcase
  end

  // Operand registers load on any IDLE request; only the long ops ever read them back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      mul_signed <= 1'b0;
      mul_neg    <= 1'b0;
`ifdef ALU_DIV_EN
      dquot      <= '0;
      ddiv       <= '0;
      drem       <= '0;
      rem_sel    <= 1'b0;
`endif
      out_valid  <= 1'b0;
      dst        <= '0;
      ov         <= 1'b0;
      zr         <= 1'b0;
      neg        <= 1'b0;
    end else begin
      out_valid <= res_fire;
      if (res_fire) begin
        dst <= res_val;
        ov  <= res_ov;
        zr  <= (res_val == '0);
        neg <= res_val[WIDTH-1];
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt        <= '0;
            mcand      <= {{WIDTH{1'b0}}, mag(src1, func == F_MULS)};
            mplier     <= mag(src0, func == F_MULS);
            prod       <= '0;
            mul_signed <= (func == F_MULS);
            mul_neg    <= (func == F_MULS) && (src1[WIDTH-1] ^ src0[WIDTH-1]);
`ifdef ALU_DIV_EN
            dquot      <= src1;
            ddiv       <= src0;
            drem       <= '0;
            rem_sel    <= (func == F_REMU);
`endif
          end
        end
        S_MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          drem  <= rem_next;
          dquot <= quot_next;
          cnt   <= cnt + SHW'(1);
        end
`endif
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
